// File: rtl/uart_pkg.sv
// Items shared by the UART transmitter and receiver: baud limits, cfg encodings,
// frame FSM state codes and the cfg_bits -> last-bit-index mapping.
package uart_pkg;

    localparam logic [15:0] BAUD_LIM_115200 = 16'd867;
    localparam logic [15:0] BAUD_LIM_19200  = 16'd5207;
    localparam logic [15:0] BAUD_LIM_9600   = 16'd10415;
    localparam logic [15:0] BAUD_LIM_TEST   = 16'd0;

    localparam logic [1:0] BAUD_115200 = 2'b00;
    localparam logic [1:0] BAUD_19200  = 2'b01;
    localparam logic [1:0] BAUD_9600   = 2'b10;
    localparam logic [1:0] BAUD_TEST   = 2'b11;

    localparam logic [1:0] BITS_5 = 2'b00;
    localparam logic [1:0] BITS_6 = 2'b01;
    localparam logic [1:0] BITS_7 = 2'b10;
    localparam logic [1:0] BITS_8 = 2'b11;

    localparam int MAX_BITS = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t START  = 3'd1;
    localparam state_t DATA   = 3'd2;
    localparam state_t PARITY = 3'd3;
    localparam state_t STOP   = 3'd4;

    function automatic logic [15:0] baud_limit(input logic [1:0] baud);
        case (baud)
            BAUD_115200: return BAUD_LIM_115200;
            BAUD_19200:  return BAUD_LIM_19200;
            BAUD_9600:   return BAUD_LIM_9600;
            default:     return BAUD_LIM_TEST;
        endcase
    endfunction

    // Index of the last data bit: 5 bits -> 4 ... 8 bits -> 7.
    function automatic logic [2:0] bit_limit(input logic [1:0] bits);
        return {1'b1, bits};
    endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for the asynchronous serial line plus a delay flop
// for falling-edge detection. Flops reset high so an idle line never looks like a start.
module uart_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic meta;
    logic sync_q;
    logic dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            sync_q <= 1'b1;
            dly    <= 1'b1;
        end else begin
            meta   <= i_async;
            sync_q <= meta;
            dly    <= sync_q;
        end
    end

    assign o_sync = sync_q;
    assign o_fall = dly & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start qualification, 5-8 data bits LSB-first, optional even parity,
// stop check. Define UART_RX_MAJORITY_EN for 2-of-3 majority voting at each sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rx_serial,
    input  logic                  i_cfg_parity,
    input  logic [1:0]            i_cfg_bits,
    input  logic [1:0]            i_cfg_baud,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_rx_busy,
    output logic                  o_parity_err,
    output logic                  o_frame_err
);

    localparam int COPY_W = (DATA_WIDTH < MAX_BITS) ? DATA_WIDTH : MAX_BITS;

    logic                  rx_s;
    logic                  rx_fall;
    state_t                state;
    logic [15:0]           baud_cnt;
    logic [15:0]           lim_q;
    logic [15:0]           half;
    logic [15:0]           pt_start;
    logic [15:0]           pt_cur;
    logic [2:0]            bit_cnt;
    logic [2:0]            bit_lmt_q;
    logic                  par_en_q;
    logic                  par_acc;
    logic                  par_bad;
    logic                  smp;
    logic                  at_pt;
    logic [MAX_BITS-1:0]   shift;
    logic [DATA_WIDTH-1:0] data_ext;

    uart_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_rx_serial),
        .o_sync  (rx_s),
        .o_fall  (rx_fall)
    );

    assign half   = lim_q >> 1;
    assign pt_cur = (state == START) ? pt_start : lim_q;
    assign at_pt  = (baud_cnt == pt_cur);

`ifdef UART_RX_MAJORITY_EN
    logic maj_a;
    logic maj_b;
    logic bypass;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Start is decided one count late; later decisions at count L keep the L+1 spacing
    // with each vote window centred where the single sample would have been.
    assign bypass   = (lim_q == 16'd0);
    assign pt_start = bypass ? half : half + 16'd1;
    assign smp      = bypass ? rx_s : vote3(maj_a, maj_b, rx_s);

    always_ff @(posedge clk) begin
        if (baud_cnt == pt_cur - 16'd2) maj_a <= rx_s;
        if (baud_cnt == pt_cur - 16'd1) maj_b <= rx_s;
    end
`else
    assign pt_start = half;
    assign smp      = rx_s;
`endif

    always_comb begin
        data_ext = '0;
        for (int i = 0; i < COPY_W; i++) data_ext[i] = shift[i];
    end

    // Shift register is fully cleared at start qualification, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == START && at_pt) begin
            shift <= '0;
        end else if (state == DATA && at_pt) begin
            shift[bit_cnt] <= smp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            lim_q        <= '0;
            bit_lmt_q    <= '0;
            par_en_q     <= 1'b0;
            par_acc      <= 1'b0;
            par_bad      <= 1'b0;
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        baud_cnt  <= '0;
                        lim_q     <= baud_limit(i_cfg_baud);
                        bit_lmt_q <= bit_limit(i_cfg_bits);
                        par_en_q  <= i_cfg_parity;
                        state     <= START;
                    end
                end
                START: begin
                    if (at_pt) begin
                        baud_cnt <= '0;
                        if (!smp) begin
                            bit_cnt <= '0;
                            par_acc <= 1'b0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (at_pt) begin
                        baud_cnt <= '0;
                        par_acc  <= par_acc ^ smp;
                        if (bit_cnt == bit_lmt_q) begin
                            state <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (at_pt) begin
                        baud_cnt <= '0;
                        par_bad  <= smp ^ par_acc;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
                    if (at_pt) begin
                        baud_cnt     <= '0;
                        state        <= IDLE;
                        o_rx_data    <= data_ext;
                        o_rx_valid   <= 1'b1;
                        o_frame_err  <= ~smp;
                        o_parity_err <= par_bad & par_en_q;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_rx_busy = (state != IDLE);

endmodule
